// File: rtl/fetch_prefetch.sv
// -----------------------------------------------------------------------------
// fetch_prefetch
//
// Instruction prefetch stage sitting directly upstream of the icache. It walks
// sequential word addresses starting from the reset PC or a redirect target,
// issues one icache read at a time, and buffers returned words together with
// their PC in a small FIFO that the CPU drains over a valid/ready handshake.
// A redirect flushes the FIFO and discards any fetch still in flight.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   fetch_en            allow new icache requests (buffered words still drain)
//   redirect            one-cycle pulse: flush and restart at redirect_addr
//   redirect_addr       new fetch byte address, bits [1:0] ignored
//   cpu_valid/ready     CPU handshake for the FIFO head
//   cpu_data, cpu_pc    head instruction word and its byte address (0 if empty)
//   client_rd_req       one-cycle read request pulse to the icache
//   client_addr         request byte address, stable until the ack
//   client_rd_ack       one-cycle pulse from the icache, data valid
//   client_rd_data      returned instruction word
// -----------------------------------------------------------------------------
module fetch_prefetch #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = 24'h000100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              cpu_valid,
    input  logic              cpu_ready,
    output logic [31:0]       cpu_data,
    output logic [ADDR_W-1:0] cpu_pc,
    output logic              client_rd_req,
    output logic [ADDR_W-1:0] client_addr,
    input  logic              client_rd_ack,
    input  logic [31:0]       client_rd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // WAIT: request outstanding, its data will be kept.
    // DROP: request outstanding, its data belongs to a flushed stream.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] client_addr_q, client_addr_d;
    logic              client_rd_req_q, client_rd_req_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic [31:0]       mem_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

    logic              push;
    logic              pop;
    logic              fifo_has_room;
    logic [ADDR_W-1:0] redirect_target;

    // Low address bits of a redirect are deliberately dropped.
    logic              unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_addr[1:0];

    assign redirect_target = {redirect_addr[ADDR_W-1:2], 2'b00};
    assign fifo_has_room   = (count_q < CNT_W'(DEPTH));

    // -------------------------------------------------------------------------
    // Fetch FSM: next state, request issue and push decision
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d         = state_q;
        fetch_addr_d    = fetch_addr_q;
        client_addr_d   = client_addr_q;
        client_rd_req_d = 1'b0;
        push            = 1'b0;

        case (state_q)
            IDLE: begin
                // A stray ack here (e.g. left over from before reset) is ignored.
                if (fetch_en && !redirect && fifo_has_room) begin
                    client_rd_req_d = 1'b1;
                    client_addr_d   = fetch_addr_q;
                    fetch_addr_d    = fetch_addr_q + ADDR_W'(4);
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // The request still has to retire; only its data is lost.
                    state_d = client_rd_ack ? IDLE : DROP;
                end else if (client_rd_ack) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                // The ack retires the old request even if another redirect
                // arrives in the same cycle; the new target is already latched.
                if (client_rd_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            fetch_addr_d = redirect_target;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO bookkeeping. A redirect flush wins over a same-cycle push or pop.
    // -------------------------------------------------------------------------
    assign pop = (count_q != '0) && cpu_ready && !redirect;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge, independent of block order.
        if (reset) begin
            state_q         <= IDLE;
            fetch_addr_q    <= RESET_PC;
            client_addr_q   <= '0;
            client_rd_req_q <= 1'b0;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
        end else begin
            state_q         <= state_d;
            fetch_addr_q    <= fetch_addr_d;
            client_addr_q   <= client_addr_d;
            client_rd_req_q <= client_rd_req_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
        end
    end

    // NOTE: the FIFO storage has no reset; count_q alone says which entries are
    // meaningful, and the output mux hides stale contents while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= client_rd_data;
            mem_pc_q[wr_ptr_q]   <= client_addr_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all derived from registers only
    // -------------------------------------------------------------------------
    assign cpu_valid     = (count_q != '0);
    assign cpu_data      = cpu_valid ? mem_data_q[rd_ptr_q] : 32'd0;
    assign cpu_pc        = cpu_valid ? mem_pc_q[rd_ptr_q] : '0;
    assign client_rd_req = client_rd_req_q;
    assign client_addr   = client_addr_q;

    // Issue needs room and the count cannot grow while a request is out, so a
    // push into a full FIFO means the control logic is broken.
    assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == CNT_W'(DEPTH))));

endmodule
